alu_cmd_pipeline: RTL
=====================

# alu_cmd_pipeline

- Buffered issue/capture stage that wraps the 8-bit combinational ALU (opcodes ADD=0, SUB=1, AND=2, OR=3, ROL=4, SRA=5, XOR=6, SGT=7).
- Accepts operation commands over a valid/ready interface into a small FIFO and presents the FIFO head to the ALU's `opcode/input1/input2/shiftValue` inputs.
- Registers the ALU `result`/`carryFlag` into a response register with its own valid/ready interface.
- Gives the purely combinational ALU a registered, back-pressurable pipeline boundary.

## Interface
Parameters:
- `WIDTH`, 8: operand/result width; must match the ALU.
- `DEPTH`, 4: command FIFO entries; power of two, >= 2.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_opcode`  in  4  operation code.
- `cmd_a`  in  WIDTH  operand 1.
- `cmd_b`  in  WIDTH  operand 2.
- `cmd_shift`  in  5  shift/rotate amount.
- `cmd_tag`  in  4  opaque ID, returned with the response.
- `alu_opcode`  out  4  to ALU `opcode`.
- `alu_input1`  out  WIDTH  to ALU `input1`.
- `alu_input2`  out  WIDTH  to ALU `input2`.
- `alu_shiftValue`  out  5  to ALU `shiftValue`.
- `alu_result`  in  WIDTH  from ALU `result`.
- `alu_carry`  in  1  from ALU `carryFlag`.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_carry`  out  1  captured carry/borrow.
- `rsp_err`  out  1  opcode was illegal (8..15).
- `rsp_tag`  out  4  tag of the command.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `ops_done`  out  16  completed-response counter.

## Operation
- **Push:** `cmd_valid && cmd_ready`. Writes {opcode, a, b, shift, tag} at the write pointer.
- **cmd_ready:** `cmd_ready = (count < DEPTH)`. It does not consider a same-cycle pop, so a full FIFO stalls input for one cycle even while draining.
- **ALU drive:** ALU inputs come straight from the head entry's storage (registered source). They are all zero when the FIFO is empty.
- **Capture/pop:** when the FIFO is non-empty and (`!rsp_valid` or `rsp_ready`), the block pops the head and loads the response register from the ALU outputs plus the head tag.
- **Result override rules at capture:**
  - ADD/SUB: `rsp_result = alu_result`, `rsp_carry = alu_carry`. For SUB, the carry is the borrow, i.e. bit WIDTH of the (WIDTH+1)-bit `{0,a}-{0,b}`.
  - AND, OR, ROL, SRA, XOR: `rsp_result = alu_result`, `rsp_carry = 0`.
  - SGT: the ALU output is ignored. `rsp_result = {WIDTH-1 zeros, $signed(a) > $signed(b)}`, `rsp_carry = 0`.
  - Opcode 8..15: `rsp_result = 0`, `rsp_carry = 0`, `rsp_err = 1`. Otherwise `rsp_err = 0`.
- **Response hold:** `rsp_*` fields hold stable while `rsp_valid && !rsp_ready`.
- **rsp_valid clear:** `rsp_valid` clears on a handshake when no new capture happens in the same cycle.
- **Simultaneous push and pop:** `count` unchanged. Pointers wrap modulo DEPTH.
- **ops_done:** increments on every `rsp_valid && rsp_ready`; wraps 0xFFFF -> 0.

## Timing
- **Reset (async):** all outputs 0, including `cmd_ready`. Pointers, `count`, `ops_done` and all FIFO entries are cleared.
- **After reset release:** `cmd_ready` = 1 from the first clock after release.
- **Reset mid-operation:** all buffered commands and any pending response are discarded. No response is emitted for them.
- **Latency:** a command pushed at edge N appears on `alu_*` after edge N. It is captured at edge N+1, so `rsp_valid` is high after edge N+1, i.e. 2 edges from push to visible response when unstalled.
- **Throughput:** 1 command/cycle sustained with `rsp_ready` held high.
- **Combinational paths:**
  - `cmd_ready` depends only on `count` (registered).
  - No combinational path from `rsp_ready` to `cmd_ready`.
  - `rsp_ready` to the internal pop decision is combinational, with no output dependency.
- **Response ordering:** responses are returned strictly in command order.

## Test plan
- **Reset and single ADD:** reset, then push ADD a=0xF0 b=0x20 tag=3 with `rsp_ready`=1. Required: `rsp_valid` after 2 edges, result 0x10, carry 1, err 0, tag 3, `ops_done`=1.
- **SUB borrow and SGT:** SUB a=0x05 b=0x06 -> result 0xFF, carry 1. SGT a=0x80 b=0x7F -> result 0x00. SGT a=0x01 b=0xFF -> result 0x01, carry 0.
- **Full and back-pressure:** with `rsp_ready`=0, push 6 commands. Required: first captured into the response register, next 4 fill the FIFO, `count`=4, `cmd_ready`=0. Then release `rsp_ready`: 5 responses in order with unchanged values while stalled, then `cmd_ready` returns to 1.
- **Illegal opcode and logic ops:**
  - Opcode 0xC -> result 0, err 1.
  - ROL a=0x81 shift=1 -> 0x03, carry 0.
  - SRA a=0x80 shift=3 -> 0xF0.
- **Streaming with random `rsp_ready`:** 200 random commands. Required: every response matches the reference model, tags in order, `ops_done`=200.
- **Reset mid-stream:** assert `rst_n`=0 with 3 entries buffered and `rsp_valid`=1. Required: all outputs 0 immediately, and after release no stale response appears.

Source files
------------

// File: rtl/alu_cmd_pipeline.sv
// alu_cmd_pipeline: small command FIFO in front of a purely combinational
// ALU, plus a registered response stage behind it. Gives the ALU a
// registered, back-pressurable pipeline boundary on both sides.
//
// Handshakes (cmd_* and rsp_*): a transfer happens on a rising clk edge where
// valid && ready are both high; the sender holds valid and payload stable
// until that edge; ready never depends combinationally on valid.
module alu_cmd_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_opcode,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  input  logic [4:0]             cmd_shift,
  input  logic [3:0]             cmd_tag,
  output logic [3:0]             alu_opcode,
  output logic [WIDTH-1:0]       alu_input1,
  output logic [WIDTH-1:0]       alu_input2,
  output logic [4:0]             alu_shiftValue,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_carry,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_carry,
  output logic                   rsp_err,
  output logic [3:0]             rsp_tag,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            ops_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_ROL = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SGT = 4'd7;

  logic [3:0]       op_mem    [DEPTH];
  logic [WIDTH-1:0] a_mem     [DEPTH];
  logic [WIDTH-1:0] b_mem     [DEPTH];
  logic [4:0]       shift_mem [DEPTH];
  logic [3:0]       tag_mem   [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             started;
  logic             empty;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] cap_result;
  logic             cap_carry;
  logic             cap_err;

  // cmd_ready is held low until the first clock after reset release, and
  // otherwise looks only at the registered occupancy (no same-cycle pop).
  assign empty     = (count == '0);
  assign cmd_ready = started && (count < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !empty && (!rsp_valid || rsp_ready);

  // The ALU is fed straight from the head entry's storage; zeros when empty.
  assign alu_opcode     = empty ? '0 : op_mem[rd_ptr];
  assign alu_input1     = empty ? '0 : a_mem[rd_ptr];
  assign alu_input2     = empty ? '0 : b_mem[rd_ptr];
  assign alu_shiftValue = empty ? '0 : shift_mem[rd_ptr];

  // Set once after reset release so cmd_ready stays low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) started <= 1'b0;
    else        started <= 1'b1;
  end

  // FIFO storage: write the incoming command at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_mem[i]    <= '0;
        a_mem[i]     <= '0;
        b_mem[i]     <= '0;
        shift_mem[i] <= '0;
        tag_mem[i]   <= '0;
      end
    end else if (push) begin
      op_mem[wr_ptr]    <= cmd_opcode;
      a_mem[wr_ptr]     <= cmd_a;
      b_mem[wr_ptr]     <= cmd_b;
      shift_mem[wr_ptr] <= cmd_shift;
      tag_mem[wr_ptr]   <= cmd_tag;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Capture value: pass the ALU through, force carry to zero where it has no
  // meaning, compute SGT locally, and flag opcodes the ALU does not define.
  always_comb begin
    cap_result = '0;
    cap_carry  = 1'b0;
    cap_err    = 1'b0;
    case (alu_opcode)
      OP_ADD, OP_SUB: begin
        cap_result = alu_result;
        cap_carry  = alu_carry;
      end
      OP_AND, OP_OR, OP_ROL, OP_SRA, OP_XOR: begin
        cap_result = alu_result;
      end
      OP_SGT: begin
        cap_result = {{(WIDTH-1){1'b0}}, ($signed(alu_input1) > $signed(alu_input2))};
      end
      default: begin
        cap_err = 1'b1;
      end
    endcase
  end

  // Response register: load on pop, clear on a handshake with no new load,
  // otherwise hold; count every completed response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
      ops_done   <= '0;
    end else begin
      if (pop) begin
        rsp_valid  <= 1'b1;
        rsp_result <= cap_result;
        rsp_carry  <= cap_carry;
        rsp_err    <= cap_err;
        rsp_tag    <= tag_mem[rd_ptr];
      end else if (rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
      if (rsp_valid && rsp_ready) ops_done <= ops_done + 16'd1;
    end
  end

endmodule
